// File: rtl/mem_io_access_unit_if.sv
// Bus bundle between the CPU datapath, the load/store unit, data memory and
// memory-mapped IO.
//   master : CPU/memory/IO side (drives requests, memory read data, IO replies)
//   slave  : the load/store unit (drives memory strobes, IO strobes, results)
interface mem_io_access_unit_if #(
  parameter int unsigned IO_WIDTH = 16
);
  logic                do_load;
  logic                do_store;
  logic [1:0]          size;
  logic                sign_extend;
  logic [31:0]         alu_result_as_address;
  logic [31:0]         data_from_register;
  logic [31:0]         data_from_memory;
  logic [31:0]         data_memory_address;
  logic                memory_write;
  logic [3:0]          byte_enable;
  logic [31:0]         data_to_store;
  logic [31:0]         io_address;
  logic                io_read;
  logic                io_write;
  logic [IO_WIDTH-1:0] data_to_io;
  logic                io_ready;
  logic [IO_WIDTH-1:0] data_from_io;
  logic [31:0]         mem_or_io_data_read;
  logic                stall;
  logic                align_error;
  logic                timeout;

  modport master (
    output do_load, do_store, size, sign_extend, alu_result_as_address,
           data_from_register, data_from_memory, io_ready, data_from_io,
    input  data_memory_address, memory_write, byte_enable, data_to_store,
           io_address, io_read, io_write, data_to_io, mem_or_io_data_read,
           stall, align_error, timeout
  );

  modport slave (
    input  do_load, do_store, size, sign_extend, alu_result_as_address,
           data_from_register, data_from_memory, io_ready, data_from_io,
    output data_memory_address, memory_write, byte_enable, data_to_store,
           io_address, io_read, io_write, data_to_io, mem_or_io_data_read,
           stall, align_error, timeout
  );
endinterface

// File: rtl/mem_io_access_unit.sv
// Load/store unit. Memory accesses are combinational (single cycle); IO
// accesses (address >= IO_BASE) run a ready handshake with timeout and stall
// the CPU until a one-cycle DONE state retires the instruction.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of mem_io_access_unit_if (requests, memory, IO, results)
module mem_io_access_unit #(
  parameter int unsigned IO_WIDTH       = 16,
  parameter logic [31:0] IO_BASE        = 32'hFFFF_FC00,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  mem_io_access_unit_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [IO_WIDTH-1:0] wdata_q, wdata_d;
  logic [IO_WIDTH-1:0] rdata_q, rdata_d;
  logic                dir_q, dir_d;      // 1: IO write
  logic                timeout_q, timeout_d;

  logic [31:0] addr;
  logic        is_store, is_load, is_io, misaligned, aligned_access, io_start;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] mem_load;

  assign addr     = bus.alu_result_as_address;
  assign is_store = bus.do_store;
  assign is_load  = bus.do_load & ~bus.do_store;
  assign is_io    = (addr >= IO_BASE);

  always_comb begin
    misaligned = 1'b0;
    case (bus.size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = |addr[1:0];
    endcase
  end

  assign aligned_access  = (is_store | is_load) & ~misaligned;
  assign io_start        = aligned_access & is_io;
  assign bus.align_error = (is_store | is_load) & misaligned;

  // Memory store path.
  assign bus.data_memory_address = {addr[31:2], 2'b00};
  assign bus.memory_write        = is_store & ~is_io & ~misaligned;

  always_comb begin
    bus.byte_enable   = 4'b0000;
    bus.data_to_store = bus.data_from_register;
    case (bus.size)
      2'b00: begin
        bus.data_to_store = {4{bus.data_from_register[7:0]}};
        if (bus.memory_write) bus.byte_enable = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        bus.data_to_store = {2{bus.data_from_register[15:0]}};
        if (bus.memory_write) bus.byte_enable = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        if (bus.memory_write) bus.byte_enable = 4'b1111;
      end
    endcase
  end

  // Memory load path: lane select then extend.
  always_comb begin
    lane_byte = 8'h00;
    case (addr[1:0])
      2'd0: lane_byte = bus.data_from_memory[7:0];
      2'd1: lane_byte = bus.data_from_memory[15:8];
      2'd2: lane_byte = bus.data_from_memory[23:16];
      default: lane_byte = bus.data_from_memory[31:24];
    endcase
    lane_half = addr[1] ? bus.data_from_memory[31:16] : bus.data_from_memory[15:0];
    case (bus.size)
      2'b00:   mem_load = bus.sign_extend ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      2'b01:   mem_load = bus.sign_extend ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: mem_load = bus.data_from_memory;
    endcase
  end

  // DONE presents the latched IO read data; it holds 0 after a timeout.
  always_comb begin
    bus.mem_or_io_data_read = 32'h0;
    if (state_q == StDone) begin
      if (!dir_q) bus.mem_or_io_data_read = 32'(rdata_q);
    end else if (is_load && !misaligned && !is_io) begin
      bus.mem_or_io_data_read = mem_load;
    end
  end

  // IO handshake FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dir_d     = dir_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (io_start) begin
          state_d = StReq;
          addr_d  = addr;
          wdata_d = bus.data_from_register[IO_WIDTH-1:0];
          dir_d   = is_store;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (bus.io_ready) begin
          if (!dir_q) rdata_d = bus.data_from_io;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          state_d   = StDone;
          rdata_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dir_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      dir_q     <= dir_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.io_address = addr_q;
  assign bus.data_to_io = wdata_q;
  assign bus.io_read    = (state_q == StReq) & ~dir_q;
  assign bus.io_write   = (state_q == StReq) & dir_q;
  assign bus.timeout    = timeout_q;
  assign bus.stall      = ((state_q == StIdle) & io_start) | (state_q == StReq);

endmodule

// File: tb/tb_mem_io_access_unit.sv
// Directed bench for mem_io_access_unit: a table of single-cycle memory
// vectors plus hand-written IO handshake, timeout and reset sequences.
module tb_mem_io_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_io_access_unit_if #(.IO_WIDTH(16)) bus ();

  mem_io_access_unit #(
    .IO_WIDTH      (16),
    .IO_BASE       (32'hFFFF_FC00),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [3:0]  be;
    logic        mw;
    logic [31:0] dts;
    logic [31:0] rd;
    logic        ae;
    logic        stall;
  } vec_t;

  localparam int NumVec = 17;
  vec_t vec [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mdata);
    bus.do_load               = ld;
    bus.do_store              = st;
    bus.size                  = sz;
    bus.sign_extend           = sx;
    bus.alu_result_as_address = addr;
    bus.data_from_register    = wdata;
    bus.data_from_memory      = mdata;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    //            ld    st    sz     sx    addr          wdata         mdata
    //            be       mw    dts           rd            ae    stall
    vec[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0,
                4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h0,
                4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0,
                4'b1111, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_BEEF, 32'h0,
                4'b0000, 1'b0, 32'hBEEF_BEEF, 32'h0, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'h0000_8001, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0006, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'h0000_0012, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'h0000_0080, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h8001_1234,
                4'b0000, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FBFC, 32'h0, 32'hCAFE_F00D,
                4'b0000, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344, 32'h5566_7788,
                4'b1111, 1'b1, 32'h1122_3344, 32'h0, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,
                4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FC72, 32'h0, 32'h0,
                4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h0,
                4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vec[16] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FC61, 32'h0000_1234, 32'h0,
                4'b0000, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 1'b0};

    idle_inputs();
    bus.io_ready     = 1'b0;
    bus.data_from_io = 16'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst io_read", 32'(bus.io_read), 32'h0);
    check("rst io_write", 32'(bus.io_write), 32'h0);
    check("rst timeout", 32'(bus.timeout), 32'h0);
    check("rst io_address", bus.io_address, 32'h0);
    check("rst data_to_io", 32'(bus.data_to_io), 32'h0);
    check("rst stall", 32'(bus.stall), 32'h0);

    // Single-cycle memory vectors.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vec[i].ld, vec[i].st, vec[i].sz, vec[i].sx, vec[i].addr, vec[i].wdata,
            vec[i].mdata);
      #1;
      check($sformatf("v%0d byte_enable", i), 32'(bus.byte_enable), 32'(vec[i].be));
      check($sformatf("v%0d memory_write", i), 32'(bus.memory_write), 32'(vec[i].mw));
      check($sformatf("v%0d data_to_store", i), bus.data_to_store, vec[i].dts);
      check($sformatf("v%0d read", i), bus.mem_or_io_data_read, vec[i].rd);
      check($sformatf("v%0d align_error", i), 32'(bus.align_error), 32'(vec[i].ae));
      check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vec[i].stall));
      check($sformatf("v%0d mem_addr", i), bus.data_memory_address,
            {vec[i].addr[31:2], 2'b00});
      check($sformatf("v%0d io strobes", i), {30'h0, bus.io_read, bus.io_write}, 32'h0);
    end

    // IO load, ready on the third REQ cycle; size/sign ignored for IO.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_FC70, 32'h0, 32'h0);
    #1;
    check("ioload idle stall", 32'(bus.stall), 32'h1);
    check("ioload idle io_read", 32'(bus.io_read), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.io_ready     = 1'b1;
        bus.data_from_io = 16'h5A5A;
      end
      #1;
      check($sformatf("ioload req%0d io_read", c), 32'(bus.io_read), 32'h1);
      check($sformatf("ioload req%0d stall", c), 32'(bus.stall), 32'h1);
      check($sformatf("ioload req%0d io_address", c), bus.io_address, 32'hFFFF_FC70);
    end
    @(negedge clk);
    bus.io_ready     = 1'b0;
    bus.data_from_io = 16'h0;
    #1;
    check("ioload done stall", 32'(bus.stall), 32'h0);
    check("ioload done io_read", 32'(bus.io_read), 32'h0);
    check("ioload done read", bus.mem_or_io_data_read, 32'h0000_5A5A);
    check("ioload done timeout", 32'(bus.timeout), 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ioload after stall", 32'(bus.stall), 32'h0);
    check("ioload after io_read", 32'(bus.io_read), 32'h0);

    // IO store with no ready: 15 REQ cycles then a timeout DONE.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FC60, 32'h1234_ABCD, 32'h0);
    #1;
    check("iost idle stall", 32'(bus.stall), 32'h1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("iost req%0d io_write", c), 32'(bus.io_write), 32'h1);
      check($sformatf("iost req%0d stall", c), 32'(bus.stall), 32'h1);
      check($sformatf("iost req%0d timeout", c), 32'(bus.timeout), 32'h0);
    end
    check("iost data_to_io", 32'(bus.data_to_io), 32'h0000_ABCD);
    check("iost io_address", bus.io_address, 32'hFFFF_FC60);
    @(negedge clk);
    #1;
    check("iost done io_write", 32'(bus.io_write), 32'h0);
    check("iost done timeout", 32'(bus.timeout), 32'h1);
    check("iost done stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("iost idle timeout", 32'(bus.timeout), 32'h0);
    check("iost idle io_write", 32'(bus.io_write), 32'h0);

    // IO store exactly at IO_BASE; early ready in IDLE must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FC00, 32'h0000_BEEF, 32'h0);
    bus.io_ready = 1'b1;
    #1;
    check("base idle stall", 32'(bus.stall), 32'h1);
    check("base idle io_write", 32'(bus.io_write), 32'h0);
    @(negedge clk);
    #1;
    check("base req io_write", 32'(bus.io_write), 32'h1);
    check("base req io_address", bus.io_address, 32'hFFFF_FC00);
    check("base req data_to_io", 32'(bus.data_to_io), 32'h0000_BEEF);
    @(negedge clk);
    bus.io_ready = 1'b0;
    #1;
    check("base done io_write", 32'(bus.io_write), 32'h0);
    check("base done stall", 32'(bus.stall), 32'h0);
    check("base done timeout", 32'(bus.timeout), 32'h0);
    @(negedge clk);
    idle_inputs();

    // Reset during the second REQ cycle aborts the access.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FC70, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("abort req1 io_read", 32'(bus.io_read), 32'h1);
    @(negedge clk);
    #1;
    check("abort req2 io_read", 32'(bus.io_read), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_CAFE);
    #1;
    check("abort io_read", 32'(bus.io_read), 32'h0);
    check("abort timeout", 32'(bus.timeout), 32'h0);
    check("abort stall", 32'(bus.stall), 32'h0);
    check("abort mem read", bus.mem_or_io_data_read, 32'h0BAD_CAFE);
    @(negedge clk);
    #1;
    check("abort next stall", 32'(bus.stall), 32'h0);
    check("abort next timeout", 32'(bus.timeout), 32'h0);
    check("abort next io_read", 32'(bus.io_read), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_access_unit.md
Name: mem_io_access_unit

Overview:
- Parametrised load/store unit between the ALU/register file and the data memory / memory-mapped IO.
- Decodes the address into memory or IO space and supports byte, half and word loads/stores with sign/zero extension and byte enables.
- Memory accesses complete in the same cycle. IO accesses run through a ready-handshake FSM with timeout and stall the CPU until done.

Parameters:
- IO_WIDTH, 16, width of the IO data bus (1..32).
- IO_BASE, 32'hFFFF_FC00, addresses >= IO_BASE are IO space; all others are memory.
- TIMEOUT_CYCLES, 15, max cycles in REQ waiting for iIoReady (>=1).
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the wait counter.

Ports:
- iClock  in  1  system clock, rising edge
- iReset  in  1  synchronous, active-high reset
- iDoLoad  in  1  load instruction, from Controller
- iDoStore  in  1  store instruction, from Controller
- iSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- iSignExtend  in  1  1: sign-extend sub-word loads; 0: zero-extend
- iAluResultAsAddress  in  32  effective address
- iDataFromRegister  in  32  store data, from register file
- iDataFromMemory  in  32  word read from data memory
- oDataMemoryAddress  out  32  {address[31:2],2'b00}
- oMemoryWrite  out  1  memory write strobe
- oByteEnable  out  4  memory byte-lane enables
- oDataToStore  out  32  lane-replicated store data to memory
- oIoAddress  out  32  latched IO address
- oIoRead  out  1  IO read request
- oIoWrite  out  1  IO write request
- oDataToIo  out  IO_WIDTH  latched IO write data
- iIoReady  in  1  IO completion
- iDataFromIo  in  IO_WIDTH  IO read data, valid when iIoReady=1
- oMemOrIODataRead  out  32  load result to register file
- oStall  out  1  freeze PC/pipeline
- oAlignError  out  1  misaligned access (combinational)
- oTimeout  out  1  one-cycle pulse: IO access timed out

Behaviour:
Decode and alignment
- iDoStore has priority; iDoLoad is ignored when both are high.
- isIo = (address >= IO_BASE), unsigned compare.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. A misaligned access sets oAlignError=1, suppresses all writes and IO requests, and returns a load result of 0.

Memory stores (combinational)
- oMemoryWrite = store & !isIo & aligned.
- oByteEnable:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - 4'b0000 when oMemoryWrite=0.
- oDataToStore:
  - byte: {4{data[7:0]}}
  - half: {2{data[15:0]}}
  - word: data

Memory loads (combinational)
- Select byte lane addr[1:0] or half lane addr[1], then extend per iSignExtend.

FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE: an aligned IO load/store moves to REQ at the next edge. On that edge, latch oIoAddress = address, oDataToIo = iDataFromRegister[IO_WIDTH-1:0], the direction, and clear the counter.
- REQ: oIoRead or oIoWrite held high.
  - iIoReady=1: latch iDataFromIo on a read, then go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no ready, go to DONE, latch read data = 0 and set oTimeout.
- DONE: strobes low and oStall=0 for exactly one cycle so the CPU retires the instruction. oTimeout is high in this cycle only if the access timed out. Next state is always IDLE.

IO rules
- oStall = (IDLE & aligned IO access) | REQ. It is 0 in DONE.
- IO loads ignore iSize and iSignExtend. Result = {zeros, latched IO data}, presented in DONE.
- iIoReady outside REQ is ignored.

Reset
- Reset values: oIoRead=0, oIoWrite=0, oTimeout=0, oIoAddress=0, oDataToIo=0, latched read data=0, counter=0.
- Reset in REQ aborts the access: strobes are low from the cycle after the reset edge, and no DONE cycle occurs.

Test Plan:
- Store byte 0xA5, addr 0x0000_0013 -> oByteEnable=4'b1000, oDataToStore=0xA5A5A5A5, oMemoryWrite=1, oStall=0.
- Load half, addr 0x0000_0002, memory 0x8001_1234, iSignExtend=1 -> result 0xFFFF8001; with iSignExtend=0 -> 0x00008001.
- Load word, addr 0x0000_0006 -> oAlignError=1, oByteEnable=0, result 0, no IO strobes.
- IO load at 0xFFFF_FC70, iIoReady asserted on the 3rd REQ cycle with data 0x5A5A -> oStall high for 4 cycles (IDLE + 3 REQ), DONE result 0x00005A5A, oIoRead low in DONE.
- IO store at 0xFFFF_FC60, data 0x1234_ABCD, iIoReady never asserted -> 15 REQ cycles with oIoWrite=1, oDataToIo=0xABCD, then one DONE cycle with oTimeout=1, then IDLE.
- iReset pulsed in the 2nd REQ cycle -> IDLE next cycle, oIoRead=0, oTimeout=0, a following memory load completes with no stall.
